four_bit_full_adder: RTL and testbench

Registered 4-bit unsigned adder with no carry-in, producing a 4-bit sum and a carry-out. Internally it is a ripple chain of four one-bit full-adder cells, with the stage-0 carry-in tied to 0. Sum, carry and a valid flag are captured in an output register stage. It serves as the basic arithmetic leaf in the datapath and accepts one operand pair per clock.

---
 rtl/four_bit_full_adder.sv | 75 +++++++
 tb/tb_four_bit_full_adder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/four_bit_full_adder.sv
// Registered 4-bit unsigned adder built from a ripple chain of four full-adder cells, carry-in tied to 0.
// Latency: 1 cycle from an accepted pair to Sum/Cout with out_valid; one pair per clock, no bubbles.
// Backpressure: none; every in_valid pair is accepted, outputs hold while idle, sync reset wins.

// One-bit full-adder cell: sum and carry from two operand bits and a carry-in.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_p;

  // Propagate term is shared between the sum and the carry equations.
  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

module four_bit_full_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       out_valid
);

  // Carry chain: w_carry[0] is the hard-wired zero carry-in, w_carry[4] is the carry-out.
  logic [4:0] w_carry;
  logic [3:0] w_sum;

  logic [3:0] r_sum;
  logic       r_cout;
  logic       r_out_valid;

  assign w_carry[0] = 1'b0;

  // Ripple chain FA0..FA3; each stage consumes the carry of the stage below it.
  for (genvar g = 0; g < 4; g++) begin : g_fa
    fa_cell u_fa (
      .i_a (A[g]),
      .i_b (B[g]),
      .i_c (w_carry[g]),
      .o_s (w_sum[g]),
      .o_c (w_carry[g+1])
    );
  end

  // Output register: reset first, then load on a valid pair; data holds when idle, valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= 4'b0000;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[4];
      end
    end
  end

  // Outputs come straight from flops, so there is no input-to-output combinational path.
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Directed bench for four_bit_full_adder: reset, basic adds, boundaries, sweep with mid-stream reset, gaps.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point after the next edge.
// Each result is checked exactly one cycle after its pair was presented.
module tb_four_bit_full_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Sum;
  logic       Cout;
  logic       out_valid;

  int checks;
  int errors;

  four_bit_full_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Sum       (Sum),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and move to the sampling point just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed directed and boundary vectors: A, B, Cout, Sum.
  logic [3:0] d_a    [7] = '{4'd0, 4'd2,  4'd4,  4'd8,  4'd15, 4'd15, 4'd7};
  logic [3:0] d_b    [7] = '{4'd0, 4'd15, 4'd14, 4'd10, 4'd15, 4'd1,  4'd8};
  logic       d_cout [7] = '{1'b0, 1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
  logic [3:0] d_sum  [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b1110, 4'b0000, 4'b1111};

  // Gap sequence: in_valid, A, B and the hand-computed outputs one cycle later.
  logic       g_v    [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] g_a    [6] = '{4'd3, 4'd9, 4'd9, 4'd1, 4'd12, 4'd0};
  logic [3:0] g_b    [6] = '{4'd4, 4'd9, 4'd9, 4'd1, 4'd4,  4'd15};
  logic       g_ov   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       g_cout [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] g_sum  [6] = '{4'd7, 4'd7, 4'd2, 4'd2, 4'd0, 4'd0};

  initial begin
    logic [4:0] exp5;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    A        = 4'hF;
    B        = 4'hF;

    // Reset held for two edges while a valid pair is presented: it must be discarded.
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_sum",  32'(Sum),       32'd0);
      chk("rst_cout", 32'(Cout),      32'd0);
      chk("rst_ov",   32'(out_valid), 32'd0);
    end
    rst = 1'b0;

    // Basic adds and boundaries, one pair per cycle.
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      A = d_a[k];
      B = d_b[k];
      step();
      chk("dir_ov",   32'(out_valid), 32'd1);
      chk("dir_cout", 32'(Cout),      32'(d_cout[k]));
      chk("dir_sum",  32'(Sum),       32'(d_sum[k]));
    end

    // Exhaustive back-to-back sweep with a one-cycle reset at i=128; that pair is re-presented after reset.
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      A = 4'(i >> 4);
      B = 4'(i);
      if (i == 128) begin
        rst = 1'b1;
        step();
        chk("mid_rst_sum",  32'(Sum),       32'd0);
        chk("mid_rst_cout", 32'(Cout),      32'd0);
        chk("mid_rst_ov",   32'(out_valid), 32'd0);
        rst = 1'b0;
      end
      exp5 = {1'b0, A} + {1'b0, B};
      step();
      chk("sweep_ov",  32'(out_valid),   32'd1);
      chk("sweep_res", 32'({Cout, Sum}), 32'(exp5));
    end

    // Alternating valid/idle cycles: out_valid follows in_valid one cycle late, data holds when idle.
    for (int k = 0; k < 6; k++) begin
      in_valid = g_v[k];
      A = g_a[k];
      B = g_b[k];
      step();
      chk("gap_ov",   32'(out_valid), 32'(g_ov[k]));
      chk("gap_cout", 32'(Cout),      32'(g_cout[k]));
      chk("gap_sum",  32'(Sum),       32'(g_sum[k]));
    end

    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
